// File: rtl/sequence_counter.sv
// -----------------------------------------------------------------------------
// sequence_counter
//   Instruction step sequencer for the control unit. Produces the 4-bit step
//   number T0..LAST_STEP that the step decoder expands into the one-hot
//   TimeSteps bus. Two states: HALT (counter parked at 0) and RUN (counter
//   advances one step per cycle unless cleared, stalled or halted).
//
// Parameters
//   LAST_STEP   highest legal step (1..15); stepping past it wraps to 0 and
//               raises Wrapped / WrapError.
//
// Ports
//   Clk          in   system clock, rising edge
//   Reset_n      in   asynchronous active-low reset
//   Start        in   HALT -> RUN at T0 (ignored in RUN, loses to Halt)
//   Halt         in   RUN -> HALT, counter back to 0
//   Clear        in   end of instruction, next step T0 (RUN only)
//   Stall        in   hold current step (RUN only)
//   StepCounter  out  current step, registered
//   Running      out  1 while in RUN
//   InstrDone    out  one-cycle pulse after an accepted Clear
//   Wrapped      out  one-cycle pulse after a LAST_STEP -> 0 wrap
//   WrapError    out  sticky Wrapped, cleared by reset or accepted Start
// -----------------------------------------------------------------------------
module sequence_counter #(
   parameter int unsigned LAST_STEP = 15
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       Start,
   input  logic       Halt,
   input  logic       Clear,
   input  logic       Stall,
   output logic [3:0] StepCounter,
   output logic       Running,
   output logic       InstrDone,
   output logic       Wrapped,
   output logic       WrapError
);

   localparam logic [3:0] LAST = LAST_STEP[3:0];

   typedef enum logic {
      S_HALT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] step_q,  step_d;
   logic       done_q,  done_d;
   logic       wrap_q,  wrap_d;
   logic       werr_q,  werr_d;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      done_d  = 1'b0;   // pulses: zero unless set this cycle
      wrap_d  = 1'b0;
      werr_d  = werr_q;
      case (state_q)
         S_HALT: begin
            step_d = 4'd0;
            if (Start && !Halt) begin
               state_d = S_RUN;
               werr_d  = 1'b0;
            end
         end
         S_RUN: begin
            if (Halt) begin
               // in-flight step abandoned, no pulse
               state_d = S_HALT;
               step_d  = 4'd0;
            end else if (Clear) begin
               // completion takes precedence over a wrap at LAST_STEP
               step_d = 4'd0;
               done_d = 1'b1;
            end else if (Stall) begin
               step_d = step_q;
            end else if (step_q >= LAST) begin
               // >= also pulls any out-of-range value back into range
               step_d = 4'd0;
               wrap_d = 1'b1;
               werr_d = 1'b1;
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         default: begin
            state_d = S_HALT;
            step_d  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_HALT;
         step_q  <= 4'd0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         werr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         werr_q  <= werr_d;
      end
   end

   assign StepCounter = step_q;
   assign Running     = (state_q == S_RUN);
   assign InstrDone   = done_q;
   assign Wrapped     = wrap_q;
   assign WrapError   = werr_q;

endmodule

// File: tb/tb_sequence_counter.sv
module tb_sequence_counter;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       Start, Halt, Clear, Stall;
   logic [3:0] step_a, step_b;
   logic       run_a, done_a, wrap_a, werr_a;
   logic       run_b, done_b, wrap_b, werr_b;

   always #5 Clk = ~Clk;

   sequence_counter #(.LAST_STEP(15)) u_a (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
      .Clear(Clear), .Stall(Stall), .StepCounter(step_a), .Running(run_a),
      .InstrDone(done_a), .Wrapped(wrap_a), .WrapError(werr_a));

   sequence_counter #(.LAST_STEP(4)) u_b (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
      .Clear(Clear), .Stall(Stall), .StepCounter(step_b), .Running(run_b),
      .InstrDone(done_b), .Wrapped(wrap_b), .WrapError(werr_b));

   // inputs {Start,Halt,Clear,Stall}; expected step; flags {Running,InstrDone,Wrapped,WrapError}
   typedef struct {
      logic [3:0] in;
      logic [3:0] step;
      logic [3:0] fl;
   } vec_t;

   vec_t va[$];
   vec_t vb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   localparam logic [3:0] I_NONE  = 4'b0000;
   localparam logic [3:0] I_START = 4'b1000;
   localparam logic [3:0] I_HALT  = 4'b0100;
   localparam logic [3:0] I_CLR   = 4'b0010;
   localparam logic [3:0] I_STALL = 4'b0001;

   function automatic vec_t mk(input logic [3:0] in, input logic [3:0] st, input logic [3:0] fl);
      vec_t v;
      v.in = in; v.step = st; v.fl = fl;
      return v;
   endfunction

   function automatic logic [7:0] obs(input logic sel);
      if (sel) return {step_b, run_b, done_b, wrap_b, werr_b};
      return {step_a, run_a, done_a, wrap_a, werr_a};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got step=%0d flags(run,done,wrap,werr)=%b, want step=%0d flags=%b",
                    name, act[7:4], act[3:0], exp[7:4], exp[3:0]);
   endtask

   task automatic apply(input logic [3:0] in);
      @(negedge Clk);
      {Start, Halt, Clear, Stall} = in;
      @(posedge Clk);
      #1;
   endtask

   task automatic run_tab(input logic sel);
      int n;
      n = sel ? vb.size() : va.size();
      for (int i = 0; i < n; i++) begin
         vec_t v;
         v = sel ? vb[i] : va[i];
         apply(v.in);
         chk($sformatf("%s_vec%0d", sel ? "L4" : "L15", i), obs(sel), {v.step, v.fl});
      end
   endtask

   initial begin
      // ---- LAST_STEP=15 table ----
      va.push_back(mk(I_START, 4'd0, 4'b1000));
      for (int s = 1; s <= 15; s++) va.push_back(mk(I_NONE, 4'(s), 4'b1000));
      va.push_back(mk(I_NONE, 4'd0, 4'b1011));       // wrap 15->0
      va.push_back(mk(I_NONE, 4'd1, 4'b1001));
      va.push_back(mk(I_NONE, 4'd2, 4'b1001));
      va.push_back(mk(I_NONE, 4'd3, 4'b1001));
      va.push_back(mk(I_CLR,  4'd0, 4'b1101));       // clear at 3
      for (int s = 1; s <= 5; s++) va.push_back(mk(I_NONE, 4'(s), 4'b1001));
      for (int k = 0; k < 3; k++) va.push_back(mk(I_STALL, 4'd5, 4'b1001));
      va.push_back(mk(I_NONE, 4'd6, 4'b1001));
      va.push_back(mk(I_CLR | I_STALL, 4'd0, 4'b1101));
      for (int s = 1; s <= 7; s++) va.push_back(mk(I_NONE, 4'(s), 4'b1001));
      va.push_back(mk(I_HALT, 4'd0, 4'b0001));       // halt at 7
      va.push_back(mk(I_HALT | I_START, 4'd0, 4'b0001));
      va.push_back(mk(I_CLR | I_STALL, 4'd0, 4'b0001));
      va.push_back(mk(I_START, 4'd0, 4'b1000));      // WrapError cleared
      va.push_back(mk(I_START, 4'd1, 4'b1000));      // Start ignored in RUN
      va.push_back(mk(I_NONE,  4'd2, 4'b1000));

      // ---- LAST_STEP=4 table ----
      vb.push_back(mk(I_START, 4'd0, 4'b1000));
      for (int s = 1; s <= 4; s++) vb.push_back(mk(I_NONE, 4'(s), 4'b1000));
      vb.push_back(mk(I_NONE, 4'd0, 4'b1011));       // wrap 4->0
      for (int s = 1; s <= 4; s++) vb.push_back(mk(I_NONE, 4'(s), 4'b1001));
      vb.push_back(mk(I_CLR,  4'd0, 4'b1101));       // clear at LAST: no wrap
      vb.push_back(mk(I_NONE, 4'd1, 4'b1001));

      Reset_n = 1'b0;
      {Start, Halt, Clear, Stall} = 4'b0000;
      #12;
      chk("reset_a", obs(1'b0), 8'h00);
      chk("reset_b", obs(1'b1), 8'h00);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      apply(I_NONE);
      chk("idle_after_reset", obs(1'b0), 8'h00);

      run_tab(1'b0);

      // advance to step 9 then drop reset mid-cycle
      for (int s = 3; s <= 9; s++) apply(I_NONE);
      chk("at_step9", obs(1'b0), {4'd9, 4'b1000});
      #2 Reset_n = 1'b0;
      #1;
      chk("async_reset_a", obs(1'b0), 8'h00);
      chk("async_reset_b", obs(1'b1), 8'h00);
      @(negedge Clk);
      Reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         apply(I_NONE);
         chk($sformatf("post_reset_hold%0d", k), obs(1'b0), 8'h00);
      end
      chk("post_reset_b", obs(1'b1), 8'h00);

      run_tab(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, got running, want finished");
      $fatal(1);
   end

endmodule
